display_driver: RTL and testbench



---
 rtl/display_pkg.sv | 37 +++
 rtl/seg7_decode.sv | 36 +++
 rtl/display_driver.sv | 78 +++++++
 tb/tb_display_driver.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the four-digit multiplexed seven-segment display driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package display_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0] idx_t;
  typedef logic [3:0] code_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;
  localparam seg_t SEG_A     = 7'h08;
  localparam seg_t SEG_B     = 7'h03;
  localparam seg_t SEG_C     = 7'h46;
  localparam seg_t SEG_D     = 7'h21;
  localparam seg_t SEG_E     = 7'h06;
  localparam seg_t SEG_F     = 7'h0E;
  localparam seg_t SEG_BLANK = 7'h7F;

  localparam logic [3:0] WEI_OFF  = 4'b1111;
  localparam logic [7:0] DUAN_OFF = 8'hFF;

  // Active-low one-hot digit enable for a scan slot.
  function automatic logic [3:0] wei_select(input idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit code to active-low a-g segment decoder.
// Define DISPLAY_HEX_DIGITS_EN to render codes 10-15 as hex letters; otherwise they blank.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (code_i)
      4'd0:  seg_o = SEG_0;
      4'd1:  seg_o = SEG_1;
      4'd2:  seg_o = SEG_2;
      4'd3:  seg_o = SEG_3;
      4'd4:  seg_o = SEG_4;
      4'd5:  seg_o = SEG_5;
      4'd6:  seg_o = SEG_6;
      4'd7:  seg_o = SEG_7;
      4'd8:  seg_o = SEG_8;
      4'd9:  seg_o = SEG_9;
`ifdef DISPLAY_HEX_DIGITS_EN
      4'd10: seg_o = SEG_A;
      4'd11: seg_o = SEG_B;
      4'd12: seg_o = SEG_C;
      4'd13: seg_o = SEG_D;
      4'd14: seg_o = SEG_E;
      4'd15: seg_o = SEG_F;
`else
      default: seg_o = SEG_BLANK;
`endif
    endcase
  end

endmodule

// File: rtl/display_driver.sv
// Four-digit multiplexed seven-segment driver: one digit per 200 Hz scan edge, outputs registered.
// Hex letters for codes 10-15 are enabled by defining DISPLAY_HEX_DIGITS_EN (see seg7_decode).
module display_driver
  import display_pkg::*;
(
  input  logic       clk_200Hz,
  input  logic       rst,
  input  logic       data15,
  input  logic       data14,
  input  logic       data13,
  input  logic       data12,
  input  logic       data11,
  input  logic       data10,
  input  logic       data9,
  input  logic       data8,
  input  logic       data7,
  input  logic       data6,
  input  logic       data5,
  input  logic       data4,
  input  logic       data3,
  input  logic       data2,
  input  logic       data1,
  input  logic       data0,
  input  logic       dot3,
  input  logic       dot2,
  input  logic       dot1,
  input  logic       dot0,
  output logic [3:0] sm_wei,
  output logic [7:0] sm_duan
);

  code_t      code_a [NUM_DIGITS];
  logic [3:0] dot_v;

  idx_t       idx_q, idx_d;
  logic [3:0] wei_q, wei_d;
  logic [7:0] duan_q, duan_d;
  code_t      code_sel;
  seg_t       seg_sel;

  always_comb begin
    code_a[0] = {data3,  data2,  data1,  data0};
    code_a[1] = {data7,  data6,  data5,  data4};
    code_a[2] = {data11, data10, data9,  data8};
    code_a[3] = {data15, data14, data13, data12};
    dot_v     = {dot3, dot2, dot1, dot0};
  end

  // Only the digit in the current slot is sampled; the others are ignored until their turn.
  assign code_sel = code_a[idx_q];

  seg7_decode u_decode (
    .code_i (code_sel),
    .seg_o  (seg_sel)
  );

  always_comb begin
    idx_d  = idx_q + 2'd1;
    wei_d  = wei_select(idx_q);
    duan_d = {~dot_v[idx_q], seg_sel};
  end

  always_ff @(posedge clk_200Hz) begin
    if (rst) begin
      idx_q  <= '0;
      wei_q  <= WEI_OFF;
      duan_q <= DUAN_OFF;
    end else begin
      idx_q  <= idx_d;
      wei_q  <= wei_d;
      duan_q <= duan_d;
    end
  end

  assign sm_wei  = wei_q;
  assign sm_duan = duan_q;

endmodule

// File: tb/tb_display_driver.sv
// Self-checking bench for display_driver: slot-level reference model plus directed literal vectors.
module tb_display_driver;

  logic       clk_200Hz = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] dg [4];
  logic [3:0] dt;
  logic [3:0] sm_wei;
  logic [7:0] sm_duan;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk_200Hz = ~clk_200Hz;

  display_driver dut (
    .clk_200Hz (clk_200Hz),
    .rst       (rst),
    .data15    (dg[3][3]), .data14 (dg[3][2]), .data13 (dg[3][1]), .data12 (dg[3][0]),
    .data11    (dg[2][3]), .data10 (dg[2][2]), .data9  (dg[2][1]), .data8  (dg[2][0]),
    .data7     (dg[1][3]), .data6  (dg[1][2]), .data5  (dg[1][1]), .data4  (dg[1][0]),
    .data3     (dg[0][3]), .data2  (dg[0][2]), .data1  (dg[0][1]), .data0  (dg[0][0]),
    .dot3      (dt[3]),    .dot2   (dt[2]),    .dot1   (dt[1]),    .dot0   (dt[0]),
    .sm_wei    (sm_wei),
    .sm_duan   (sm_duan)
  );

  // Full 8-bit display pattern with dp off, straight from the segment table.
  function automatic logic [7:0] glyph(input logic [3:0] c);
    case (c)
      4'd0: return 8'hC0;  4'd1: return 8'hF9;  4'd2: return 8'hA4;  4'd3: return 8'hB0;
      4'd4: return 8'h99;  4'd5: return 8'h92;  4'd6: return 8'h82;  4'd7: return 8'hF8;
      4'd8: return 8'h80;  4'd9: return 8'h90;
`ifdef DISPLAY_HEX_DIGITS_EN
      4'd10: return 8'h88; 4'd11: return 8'h83; 4'd12: return 8'hC6;
      4'd13: return 8'hA1; 4'd14: return 8'h86; default: return 8'h8E;
`else
      default: return 8'hFF;
`endif
    endcase
  endfunction

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
  endtask

  task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0, input logic [3:0] dots);
    dg[3] = d3; dg[2] = d2; dg[1] = d1; dg[0] = d0; dt = dots;
  endtask

  // Reference model: slot counter as an integer, output derived from the digit shown in that slot.
  int         m_slot  = 0;
  bit         m_valid = 1'b0;
  logic [3:0] exp_wei;
  logic [7:0] exp_duan;

  always @(posedge clk_200Hz) begin
    if (rst) begin
      m_slot   <= 0;
      exp_wei  <= 4'hF;
      exp_duan <= 8'hFF;
      m_valid  <= 1'b1;
    end else if (m_valid) begin
      exp_wei  <= 4'hF - 4'(1 << m_slot);
      exp_duan <= dt[m_slot] ? (glyph(dg[m_slot]) - 8'h80) : glyph(dg[m_slot]);
      m_slot   <= (m_slot + 1) % 4;
    end
  end

  always @(negedge clk_200Hz) begin
    if (m_valid) begin
      check8("model_wei", {4'h0, sm_wei}, {4'h0, exp_wei});
      check8("model_duan", sm_duan, exp_duan);
    end
  end

  task automatic run_vec(input string nm, input logic [3:0] d3, input logic [3:0] d2,
                         input logic [3:0] d1, input logic [3:0] d0, input logic [3:0] dots,
                         input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] ev [4];
    logic [3:0] ew [4];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    ew[0] = 4'hE; ew[1] = 4'hD; ew[2] = 4'hB; ew[3] = 4'h7;
    rst = 1'b1;
    set_digits(d3, d2, d1, d0, dots);
    @(negedge clk_200Hz);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk_200Hz);
      check8({nm, "_wei"}, {4'h0, sm_wei}, {4'h0, ew[s]});
      check8({nm, "_duan"}, sm_duan, ev[s]);
    end
  endtask

  initial begin
    logic [3:0] wseq [5];
    wseq[0] = 4'hE; wseq[1] = 4'hD; wseq[2] = 4'hB; wseq[3] = 4'h7; wseq[4] = 4'hE;

    // Reset held two edges with arbitrary data.
    rst = 1'b1;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'b0101);
    repeat (2) @(negedge clk_200Hz);
    check8("rst_wei", {4'h0, sm_wei}, 8'h0F);
    check8("rst_duan", sm_duan, 8'hFF);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_200Hz);
      check8("scan_seq_wei", {4'h0, sm_wei}, {4'h0, wseq[i]});
    end

`ifdef DISPLAY_HEX_DIGITS_EN
    run_vec("vec_442A", 4'hA, 4'h2, 4'h4, 4'h4, 4'b1000, 8'h99, 8'h99, 8'hA4, 8'h08);
`else
    run_vec("vec_442A", 4'hA, 4'h2, 4'h4, 4'h4, 4'b1000, 8'h99, 8'h99, 8'hA4, 8'h7F);
`endif
    run_vec("vec_8250", 4'h8, 4'h2, 4'h5, 4'h0, 4'b1000, 8'hC0, 8'h92, 8'hA4, 8'h00);
    run_vec("vec_0508", 4'h0, 4'h5, 4'h0, 4'h8, 4'b1000, 8'h80, 8'hC0, 8'h92, 8'h40);
    run_vec("vec_dots", 4'h3, 4'h6, 4'h9, 4'h1, 4'b0110, 8'hF9, 8'h10, 8'h02, 8'hB0);

    // Mid-scan change of digit 2 while digit 0 is on display, then reset during slot 2.
    rst = 1'b1;
    set_digits(4'd3, 4'd6, 4'd9, 4'd1, 4'b0000);
    @(negedge clk_200Hz);
    rst = 1'b0;
    @(negedge clk_200Hz);
    check8("mid_d0_wei", {4'h0, sm_wei}, 8'h0E);
    check8("mid_d0_duan", sm_duan, 8'hF9);
    dg[2] = 4'd7;
    @(negedge clk_200Hz);
    check8("mid_d1_duan", sm_duan, 8'h90);
    @(negedge clk_200Hz);
    check8("mid_d2_wei", {4'h0, sm_wei}, 8'h0B);
    check8("mid_d2_duan", sm_duan, 8'hF8);
    rst = 1'b1;
    @(negedge clk_200Hz);
    check8("mid_rst_wei", {4'h0, sm_wei}, 8'h0F);
    check8("mid_rst_duan", sm_duan, 8'hFF);
    rst = 1'b0;
    @(negedge clk_200Hz);
    check8("mid_restart_wei", {4'h0, sm_wei}, 8'h0E);
    check8("mid_restart_duan", sm_duan, 8'hF9);

    // Every code in every slot under every dot pattern; the model checks each edge.
    for (int c = 0; c < 16; c++) begin
      for (int d = 0; d < 16; d++) begin
        set_digits(4'(c + 3), 4'(c + 2), 4'(c + 1), 4'(c), 4'(d));
        repeat (4) @(negedge clk_200Hz);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
